// File: rtl/spi_slave_apb_pkg.sv
// Shared types for the SPI-slave-to-APB prefetching bridge.
// Holds the bridge FSM states and the session mode (READING / WRITING).
package spi_slave_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } apb_plug_state_e;

  typedef enum logic {
    READING = 1'b0,
    WRITING = 1'b1
  } rxtx_mode_e;

  localparam int WRAP_WIDTH = 16;

endpackage

// File: rtl/spi_slave_apb_rdfifo.sv
// Synchronous first-word-fall-through FIFO that holds prefetched APB read words.
// The flush input overrides push and pop.
module spi_slave_apb_rdfifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is masked while empty so the output never exposes stale storage.
  assign pop_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge pclk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_apb_prefetch_plug.sv
// SPI-slave word buffer to APB master bridge with read prefetch, address stride,
// optional wrapping bursts and sticky pslverr capture.
module spi_slave_apb_prefetch_plug
  import spi_slave_apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned PREFETCH_DEPTH = 4,
  parameter int unsigned ADDR_STRIDE    = APB_DATA_WIDTH / 8
) (
  input  logic                      pclk,
  input  logic                      presetn,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pready,
  input  logic                      pslverr,
  input  logic [APB_ADDR_WIDTH-1:0] rxtx_addr,
  input  logic                      rxtx_addr_valid,
  input  logic                      start_tx,
  input  logic                      cs,
  output logic [APB_DATA_WIDTH-1:0] tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic [APB_DATA_WIDTH-1:0] rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  input  logic [WRAP_WIDTH-1:0]     wrap_length,
  input  logic                      err_clear,
  output logic                      err_sticky,
  output logic                      busy
);

  localparam int CNT_W = $clog2(PREFETCH_DEPTH) + 1;
  localparam logic [APB_ADDR_WIDTH-1:0] STRIDE = APB_ADDR_WIDTH'(ADDR_STRIDE);

  apb_plug_state_e           state_reg, state_next;
  rxtx_mode_e                mode_reg;
  logic [APB_ADDR_WIDTH-1:0] base_addr_reg;
  logic [APB_ADDR_WIDTH-1:0] curr_addr_reg;
  logic [WRAP_WIDTH-1:0]     word_idx_reg;
  logic [APB_DATA_WIDTH-1:0] wdata_q_reg;
  logic                      err_sticky_reg;

  logic                      start_write;
  logic                      start_read;
  logic                      xfer_done;
  logic                      enter_idle;
  logic                      wrap_hit;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic                      prefetch_room;

  assign xfer_done     = (state_reg == ENABLE) && pready;
  assign enter_idle    = (state_reg != IDLE) && (state_next == IDLE);
  assign wrap_hit      = (wrap_length != '0) && (word_idx_reg == wrap_length - WRAP_WIDTH'(1));
  assign prefetch_room = (fifo_count < CNT_W'(PREFETCH_DEPTH));
  // A read finishing while cs is high belongs to an abandoned session.
  assign fifo_push     = xfer_done && (mode_reg == READING) && !cs && !fifo_full;
  assign fifo_pop      = tx_valid && tx_ready;

  always_comb begin
    state_next  = state_reg;
    rx_ready    = 1'b0;
    start_write = 1'b0;
    start_read  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rx_valid) begin
          rx_ready    = 1'b1;
          start_write = 1'b1;
          state_next  = SETUP;
        end else if (start_tx && !cs) begin
          start_read = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP:  state_next = ENABLE;
      ENABLE: if (pready) state_next = cs ? IDLE : HOLD;
      HOLD: begin
        if (cs) begin
          state_next = IDLE;
        end else if (mode_reg == WRITING) begin
          rx_ready = 1'b1;
          if (rx_valid) state_next = SETUP;
        end else if (prefetch_room) begin
          state_next = SETUP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg      <= IDLE;
      mode_reg       <= READING;
      base_addr_reg  <= '0;
      curr_addr_reg  <= '0;
      word_idx_reg   <= '0;
      wdata_q_reg    <= '0;
      err_sticky_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_write)      mode_reg <= WRITING;
      else if (start_read)  mode_reg <= READING;
      if (rx_valid && rx_ready) wdata_q_reg <= rx_data;

      if (state_reg == IDLE && rxtx_addr_valid) begin
        base_addr_reg <= rxtx_addr;
        curr_addr_reg <= rxtx_addr;
      end else if (xfer_done) begin
        if (wrap_hit) begin
          curr_addr_reg <= base_addr_reg;
        end else begin
          curr_addr_reg <= curr_addr_reg + STRIDE;
        end
      end

      if (enter_idle)     word_idx_reg <= '0;
      else if (xfer_done) word_idx_reg <= wrap_hit ? '0 : word_idx_reg + WRAP_WIDTH'(1);

      // A new error outranks a clear arriving in the same cycle.
      if (xfer_done && pslverr) err_sticky_reg <= 1'b1;
      else if (err_clear)       err_sticky_reg <= 1'b0;
    end
  end

  spi_slave_apb_rdfifo #(
    .DEPTH (PREFETCH_DEPTH),
    .WIDTH (APB_DATA_WIDTH)
  ) u_rdfifo (
    .pclk      (pclk),
    .presetn   (presetn),
    .flush     (enter_idle),
    .push      (fifo_push),
    .push_data (prdata),
    .pop       (fifo_pop),
    .pop_data  (tx_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign psel       = (state_reg == SETUP) || (state_reg == ENABLE);
  assign penable    = (state_reg == ENABLE);
  assign pwrite     = psel && (mode_reg == WRITING);
  assign paddr      = curr_addr_reg;
  assign pwdata     = wdata_q_reg;
  assign tx_valid   = !fifo_empty;
  assign err_sticky = err_sticky_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_slave_apb_prefetch_plug.sv
// Scoreboard bench for spi_slave_apb_prefetch_plug: expected APB transfers and
// SPI read words are queued with the stimulus and popped as the DUT produces them.
module tb_spi_slave_apb_prefetch_plug;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready = 1'b1;
  logic        pslverr;
  logic [31:0] rxtx_addr = '0;
  logic        rxtx_addr_valid = 1'b0;
  logic        start_tx = 1'b0;
  logic        cs = 1'b1;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [15:0] wrap_length = '0;
  logic        err_clear = 1'b0;
  logic        err_sticky;
  logic        busy;

  logic        pslverr_en = 1'b0;
  logic [31:0] pslverr_addr = '0;

  always #5 pclk = ~pclk;

  // Slave model: read data encodes the address; error only on a chosen address.
  assign prdata  = 32'hC0DE_0000 | paddr;
  assign pslverr = pslverr_en && psel && penable && (paddr == pslverr_addr);

  spi_slave_apb_prefetch_plug dut (
    .pclk            (pclk),
    .presetn         (presetn),
    .psel            (psel),
    .penable         (penable),
    .pwrite          (pwrite),
    .paddr           (paddr),
    .pwdata          (pwdata),
    .prdata          (prdata),
    .pready          (pready),
    .pslverr         (pslverr),
    .rxtx_addr       (rxtx_addr),
    .rxtx_addr_valid (rxtx_addr_valid),
    .start_tx        (start_tx),
    .cs              (cs),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .wrap_length     (wrap_length),
    .err_clear       (err_clear),
    .err_sticky      (err_sticky),
    .busy            (busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } apb_exp_t;

  apb_exp_t    apb_q[$];
  logic [31:0] tx_q[$];
  apb_exp_t    mon_e;
  logic [31:0] mon_w;
  int          n_checks = 0;
  int          n_pass = 0;
  int          setup_cnt = 0;
  int          rx_hs_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic expect_apb(input logic [31:0] a, input logic wr, input logic [31:0] d);
    apb_exp_t e;
    e.addr = a;
    e.wr   = wr;
    e.data = d;
    apb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic load_base(input logic [31:0] a);
    rxtx_addr       = a;
    rxtx_addr_valid = 1'b1;
    tick();
    rxtx_addr_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    bit ok;
    ok       = 1'b0;
    rx_data  = w;
    rx_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge pclk);
      if (rx_ready) ok = 1'b1;
      @(posedge pclk);
      #1;
    end
    rx_valid = 1'b0;
    check_val("rx_accept_timeout", ok, 1);
  endtask

  // Monitor: one line per APB transfer and per SPI read word.
  always @(negedge pclk) begin
    if (presetn && psel && !penable) begin
      setup_cnt++;
      check_val("apb_setup_expected", apb_q.size() != 0, 1);
      if (apb_q.size() != 0) begin
        mon_e = apb_q.pop_front();
        $display("apb %s addr=%08h wdata=%08h", pwrite ? "write" : "read ", paddr, pwdata);
        check_val("apb_paddr", paddr, mon_e.addr);
        check_val("apb_pwrite", pwrite, mon_e.wr);
        if (mon_e.wr) check_val("apb_pwdata", pwdata, mon_e.data);
      end
    end
    if (tx_valid && tx_ready) begin
      check_val("tx_word_expected", tx_q.size() != 0, 1);
      if (tx_q.size() != 0) begin
        mon_w = tx_q.pop_front();
        $display("spi tx word=%08h", tx_data);
        check_val("tx_data", tx_data, mon_w);
      end
    end
    if (rx_valid && rx_ready) begin
      rx_hs_cnt++;
      $display("spi rx word=%08h", rx_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int s0;
    int lat;

    // Reset values while presetn is held low
    #3;
    check_val("rst_outputs", {psel, penable, pwrite, tx_valid, rx_ready, err_sticky, busy}, 7'b0);
    check_val("rst_paddr", paddr, 32'h0);
    check_val("rst_pwdata", pwdata, 32'h0);
    check_val("rst_tx_data", tx_data, 32'h0);
    tick();
    tick();
    presetn = 1'b1;
    tick();

    // Read session with wrap 3, SPI never pops: prefetch fills the FIFO and stalls
    load_base(32'h100);
    wrap_length = 16'd3;
    cs          = 1'b0;
    tx_ready    = 1'b0;
    expect_apb(32'h100, 1'b0, 32'h0);
    expect_apb(32'h104, 1'b0, 32'h0);
    expect_apb(32'h108, 1'b0, 32'h0);
    expect_apb(32'h100, 1'b0, 32'h0);
    tx_q.push_back(32'hC0DE_0100);
    tx_q.push_back(32'hC0DE_0104);
    tx_q.push_back(32'hC0DE_0108);
    tx_q.push_back(32'hC0DE_0100);
    s0       = setup_cnt;
    start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    lat = 1;
    while (!tx_valid && lat < 10) begin
      tick();
      lat++;
    end
    check_val("read_latency", lat, 3);
    repeat (15) tick();
    check_val("wrap_setups_before_stall", setup_cnt - s0, 4);
    check_val("stall_psel", psel, 1'b0);
    check_val("stall_busy", busy, 1'b1);
    check_val("stall_head", tx_data, 32'hC0DE_0100);
    // One pop frees a slot: the next prefetch continues from 0x104
    expect_apb(32'h104, 1'b0, 32'h0);
    tx_q.push_back(32'hC0DE_0104);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    repeat (6) tick();
    check_val("setups_after_pop", setup_cnt - s0, 5);
    check_val("head_after_pop", tx_data, 32'hC0DE_0104);
    cs = 1'b1;
    tick();
    tick();
    check_val("read_end_busy", busy, 1'b0);
    check_val("read_end_flush", tx_valid, 1'b0);
    tx_q.delete();
    check_val("read_apb_q_drained", apb_q.size(), 0);

    // cs rises while a read waits in ENABLE: transfer completes, data discarded
    load_base(32'h200);
    wrap_length = 16'd0;
    pready      = 1'b0;
    cs          = 1'b0;
    expect_apb(32'h200, 1'b0, 32'h0);
    start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    tick();
    cs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_val("abort_hold_enable", {psel, penable}, 2'b11);
      check_val("abort_hold_paddr", paddr, 32'h200);
      tick();
    end
    pready = 1'b1;
    tick();
    check_val("abort_idle", {busy, psel, tx_valid}, 3'b000);
    tick();
    check_val("abort_no_data", tx_valid, 1'b0);

    // Linear write burst, error on the second word
    load_base(32'h300);
    cs           = 1'b0;
    rx_hs_cnt    = 0;
    pslverr_addr = 32'h304;
    pslverr_en   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_apb(32'h300 + 32'(4 * i), 1'b1, 32'hA0 + 32'(i));
      send_word(32'hA0 + 32'(i));
    end
    repeat (4) tick();
    check_val("write_rx_handshakes", rx_hs_cnt, 5);
    check_val("write_err_sticky", err_sticky, 1'b1);
    check_val("write_session_alive", busy, 1'b1);
    check_val("write_apb_q_drained", apb_q.size(), 0);
    cs = 1'b1;
    tick();
    tick();
    pslverr_en = 1'b0;
    check_val("write_end_busy", busy, 1'b0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check_val("err_clear_alone", err_sticky, 1'b0);

    // rx_valid and start_tx together start a write; error beats clear
    load_base(32'h400);
    pslverr_addr = 32'h400;
    pslverr_en   = 1'b1;
    cs           = 1'b0;
    expect_apb(32'h400, 1'b1, 32'hB0);
    rx_data  = 32'hB0;
    rx_valid = 1'b1;
    start_tx = 1'b1;
    tick();
    rx_valid = 1'b0;
    start_tx = 1'b0;
    check_val("both_start_pwrite", {psel, penable, pwrite}, 3'b101);
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check_val("err_set_beats_clear", err_sticky, 1'b1);
    check_val("both_start_hold", busy, 1'b1);
    cs = 1'b1;
    tick();
    tick();
    pslverr_en = 1'b0;

    // Asynchronous reset in the middle of ENABLE
    load_base(32'h500);
    pready = 1'b0;
    cs     = 1'b0;
    expect_apb(32'h500, 1'b0, 32'h0);
    start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    tick();
    check_val("rst_mid_in_enable", penable, 1'b1);
    #2;
    presetn = 1'b0;
    #1;
    check_val("rst_mid_async", {psel, penable, busy, tx_valid, rx_ready}, 5'b0);
    tick();
    tick();
    presetn = 1'b1;
    pready  = 1'b1;
    tick();
    check_val("rst_release_fifo_empty", tx_valid, 1'b0);
    check_val("rst_release_paddr", paddr, 32'h0);
    check_val("rst_release_idle", busy, 1'b0);
    check_val("final_apb_q_drained", apb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
